// File: rtl/aud_dsp.sv
// rtl/aud_dsp.sv - SRAM-fed playback controller with fast/slow speed control for the I2S player
module aud_dsp #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_fast,
    input  logic              i_slow_0,
    input  logic              i_slow_1,
    input  logic [2:0]        i_speed,
    input  logic              i_daclrck,
    input  logic [ADDR_W-1:0] i_end_addr,
    input  logic [DATA_W-1:0] i_sram_data,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_dac_data,
    output logic              o_player_en,
    output logic              o_done
);
    localparam int PW = DATA_W + 5;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_FETCH, S_CALC, S_PAUSE} state_t;
    typedef enum logic [1:0] {M_NORM, M_FAST, M_SLOW0, M_SLOW1} mode_t;

    state_t            state_q, state_d;
    mode_t             mode_q, mode_d;
    logic              lrck_q, lrck_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic [DATA_W-1:0] dac_q, dac_d;
    logic [2:0]        k_q, k_d;
    logic [3:0]        n_q, n_d;
    logic              done_q, done_d;
    logic              last_q, last_d;

    logic                 tick;
    logic                 wrap;
    logic [3:0]           kp1;
    logic [ADDR_W:0]      next_addr;
    logic signed [PW-1:0] diff_x, kp1_x, n_x, prod, quot, interp;
    logic [DATA_W-1:0]    interp_sat;

    assign tick = i_daclrck & ~lrck_q;
    assign kp1  = {1'b0, k_q} + 4'd1;
    assign wrap = (kp1 == n_q);

    // Interpolation datapath; PW bits keep (cur-prev)*(k+1) exact before the divide.
    always_comb begin
        diff_x = PW'($signed(i_sram_data)) - PW'($signed(prev_q));
        kp1_x  = PW'(kp1);
        n_x    = PW'(n_q);
        prod   = diff_x * kp1_x;
        quot   = prod / n_x;
        interp = PW'($signed(prev_q)) + quot;
        if (interp[PW-1:DATA_W-1] == {(PW-DATA_W+1){interp[PW-1]}}) begin
            interp_sat = interp[DATA_W-1:0];
        end else begin
            interp_sat = interp[PW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

    always_comb begin
        next_addr = {1'b0, addr_q};
        if (mode_q == M_NORM || mode_q == M_FAST) begin
            next_addr = {1'b0, addr_q} + (ADDR_W+1)'(n_q);
        end else if (wrap) begin
            next_addr = {1'b0, addr_q} + (ADDR_W+1)'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        lrck_d  = i_daclrck;
        addr_d  = addr_q;
        prev_d  = prev_q;
        dac_d   = dac_q;
        k_d     = k_q;
        n_d     = n_q;
        done_d  = 1'b0;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                dac_d = '0;
                if (i_start) begin
                    addr_d  = '0;
                    prev_d  = '0;
                    k_d     = 3'd0;
                    last_d  = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (tick) begin
                    if (last_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        dac_d   = '0;
                        addr_d  = '0;
                        last_d  = 1'b0;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (i_fast) begin
                    mode_d = M_FAST;
                    n_d    = {1'b0, i_speed} + 4'd1;
                end else if (i_slow_1) begin
                    mode_d = M_SLOW1;
                    n_d    = {1'b0, i_speed} + 4'd1;
                end else if (i_slow_0) begin
                    mode_d = M_SLOW0;
                    n_d    = {1'b0, i_speed} + 4'd1;
                end else begin
                    mode_d = M_NORM;
                    n_d    = 4'd1;
                end
                // A speed change can leave k beyond the new factor; restart the sub-sample count.
                if (mode_d == M_SLOW0 || mode_d == M_SLOW1) begin
                    if ({1'b0, k_q} >= n_d) k_d = 3'd0;
                end else begin
                    k_d = 3'd0;
                end
                state_d = S_CALC;
            end
            S_CALC: begin
                dac_d  = (mode_q == M_SLOW1) ? interp_sat : i_sram_data;
                addr_d = next_addr[ADDR_W-1:0];
                last_d = next_addr > {1'b0, i_end_addr};
                if (mode_q == M_SLOW0 || mode_q == M_SLOW1) begin
                    k_d = wrap ? 3'd0 : k_q + 3'd1;
                end
                if (next_addr != {1'b0, addr_q}) prev_d = i_sram_data;
                state_d = S_WAIT;
            end
            S_PAUSE: begin
                dac_d = '0;
                if (i_start) state_d = S_WAIT;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE) begin
            if (i_stop) begin
                state_d = S_IDLE;
                dac_d   = '0;
                addr_d  = '0;
                prev_d  = '0;
                k_d     = 3'd0;
                last_d  = 1'b0;
                done_d  = 1'b0;
            end else if (i_pause) begin
                // Pause discards any in-flight sample so resume replays the same address.
                state_d = S_PAUSE;
                dac_d   = '0;
                addr_d  = addr_q;
                prev_d  = prev_q;
                k_d     = k_q;
                last_d  = last_q;
                done_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            mode_q  <= M_NORM;
            lrck_q  <= 1'b1;
            addr_q  <= '0;
            prev_q  <= '0;
            dac_q   <= '0;
            k_q     <= 3'd0;
            n_q     <= 4'd1;
            done_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            lrck_q  <= lrck_d;
            addr_q  <= addr_d;
            prev_q  <= prev_d;
            dac_q   <= dac_d;
            k_q     <= k_d;
            n_q     <= n_d;
            done_q  <= done_d;
            last_q  <= last_d;
        end
    end

    assign o_sram_addr = addr_q;
    assign o_dac_data  = dac_q;
    assign o_done      = done_q;
    assign o_player_en = (state_q == S_WAIT) || (state_q == S_FETCH) || (state_q == S_CALC);
endmodule

// File: tb/tb_aud_dsp.sv
// tb/tb_aud_dsp.sv - scoreboard bench for aud_dsp playback, speed modes, pause, stop and reset
module tb_aud_dsp;
    logic        clk;
    logic        i_rst, i_start, i_pause, i_stop;
    logic        i_fast, i_slow_0, i_slow_1;
    logic [2:0]  i_speed;
    logic        i_daclrck;
    logic [19:0] i_end_addr;
    logic [15:0] i_sram_data;
    logic [19:0] o_sram_addr;
    logic [15:0] o_dac_data;
    logic        o_player_en, o_done;

    aud_dsp #(.ADDR_W(20), .DATA_W(16)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_pause(i_pause), .i_stop(i_stop),
        .i_fast(i_fast), .i_slow_0(i_slow_0), .i_slow_1(i_slow_1), .i_speed(i_speed),
        .i_daclrck(i_daclrck), .i_end_addr(i_end_addr), .i_sram_data(i_sram_data),
        .o_sram_addr(o_sram_addr), .o_dac_data(o_dac_data), .o_player_en(o_player_en),
        .o_done(o_done)
    );

    typedef struct {
        logic [15:0] dac;
        logic        en;
        logic        done;
        logic [19:0] addr;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mem [0:15];
    logic [3:0]  lcnt;
    logic        tb_tick;
    int          n_chk = 0;
    int          n_fail = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) i_sram_data <= mem[o_sram_addr[3:0]];

    // LR clock: 16 system clocks per frame; tb_tick marks the posedge the DUT sees as a rising edge.
    initial begin
        lcnt = 4'd0;
        i_daclrck = 1'b0;
        tb_tick = 1'b0;
        forever begin
            @(negedge clk);
            lcnt = lcnt + 4'd1;
            tb_tick = lcnt[3] & ~i_daclrck;
            i_daclrck = lcnt[3];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int dac, input logic en, input logic done, input int addr);
        exp_t e;
        e.dac  = 16'(dac);
        e.en   = en;
        e.done = done;
        e.addr = 20'(addr);
        sb.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (tb_tick && sb.size() != 0) begin
                e = sb.pop_front();
                #1;
                chk("done", 32'(o_done), 32'(e.done));
                chk("addr", 32'(o_sram_addr), 32'(e.addr));
                repeat (2) @(posedge clk);
                #1;
                chk("dac", 32'(o_dac_data), 32'(e.dac));
                chk("en", 32'(o_player_en), 32'(e.en));
            end
        end
    end

    task automatic wait_tick();
        int g = 0;
        do begin
            @(posedge clk);
            g++;
        end while (!tb_tick && g < 100);
        if (!tb_tick) chk("tick_timeout", 32'(tb_tick), 32'd1);
    endtask

    task automatic drain();
        int g = 0;
        while (sb.size() != 0 && g < 3000) begin
            @(posedge clk);
            g++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
        repeat (6) @(posedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk) i_start = 1'b1;
        @(negedge clk) i_start = 1'b0;
    endtask

    task automatic setup(input logic f, input logic s0, input logic s1, input logic [2:0] sp,
                         input int end_a, input int mul, input int v0, input int v1);
        i_fast = f; i_slow_0 = s0; i_slow_1 = s1; i_speed = sp;
        i_end_addr = 20'(end_a);
        for (int a = 0; a < 16; a++) mem[a] = 16'(a * mul);
        if (mul == 0) begin
            mem[0] = 16'(v0);
            mem[1] = 16'(v1);
        end
        wait_tick();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_pause = 1'b0; i_stop = 1'b0;
        i_fast = 1'b0; i_slow_0 = 1'b0; i_slow_1 = 1'b0; i_speed = 3'd0; i_end_addr = '0;
        for (int a = 0; a < 16; a++) mem[a] = '0;
        repeat (4) @(negedge clk);
        chk("rst_addr", 32'(o_sram_addr), 32'd0);
        chk("rst_dac", 32'(o_dac_data), 32'd0);
        chk("rst_en", 32'(o_player_en), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        i_rst = 1'b0;

        // Normal rate, SRAM[a]=a*16
        setup(1'b0, 1'b0, 1'b0, 3'd5, 3, 16, 0, 0);
        push(0, 1, 0, 0); push(16, 1, 0, 1); push(32, 1, 0, 2); push(48, 1, 0, 3);
        push(0, 0, 1, 0);
        pulse_start();
        drain();

        // Fast, N=3, SRAM[a]=a; end at 10 so 12 is the first out-of-range address
        setup(1'b1, 1'b1, 1'b1, 3'd2, 10, 1, 0, 0);
        push(0, 1, 0, 0); push(3, 1, 0, 3); push(6, 1, 0, 6); push(9, 1, 0, 9);
        push(0, 0, 1, 0);
        pulse_start();
        drain();

        // Slow repeat, N=2
        setup(1'b0, 1'b1, 1'b0, 3'd1, 1, 0, 100, 200);
        push(100, 1, 0, 0); push(100, 1, 0, 0); push(200, 1, 0, 1); push(200, 1, 0, 1);
        push(0, 0, 1, 0);
        pulse_start();
        drain();

        // Slow linear, N=4, {400,-400}
        setup(1'b0, 1'b1, 1'b1, 3'd3, 1, 0, 400, -400);
        push(100, 1, 0, 0); push(200, 1, 0, 0); push(300, 1, 0, 0); push(400, 1, 0, 0);
        push(200, 1, 0, 1); push(0, 1, 0, 1); push(-200, 1, 0, 1); push(-400, 1, 0, 1);
        push(0, 0, 1, 0);
        pulse_start();
        drain();

        // Slow linear, N=3, {-100}: -100/3 and -200/3 truncate toward zero
        setup(1'b0, 1'b0, 1'b1, 3'd2, 0, 0, -100, 0);
        push(-33, 1, 0, 0); push(-66, 1, 0, 0); push(-100, 1, 0, 0); push(0, 0, 1, 0);
        pulse_start();
        drain();

        // Pause after two samples, five paused frames, resume at address 2
        setup(1'b0, 1'b0, 1'b0, 3'd0, 3, 16, 0, 0);
        push(0, 1, 0, 0); push(16, 1, 0, 1);
        pulse_start();
        wait_tick(); wait_tick();
        repeat (4) @(negedge clk);
        i_pause = 1'b1;
        @(negedge clk) i_pause = 1'b0;
        for (int i = 0; i < 5; i++) push(0, 0, 0, 2);
        for (int i = 0; i < 5; i++) wait_tick();
        repeat (3) @(negedge clk);
        push(32, 1, 0, 2); push(48, 1, 0, 3); push(0, 0, 1, 0);
        pulse_start();
        drain();

        // Stop and pause together: stop wins
        setup(1'b0, 1'b0, 1'b0, 3'd0, 3, 16, 0, 0);
        push(0, 1, 0, 0); push(16, 1, 0, 1);
        pulse_start();
        wait_tick(); wait_tick();
        repeat (4) @(negedge clk);
        i_stop = 1'b1; i_pause = 1'b1;
        @(negedge clk);
        i_stop = 1'b0; i_pause = 1'b0;
        chk("stop_addr", 32'(o_sram_addr), 32'd0);
        chk("stop_en", 32'(o_player_en), 32'd0);
        chk("stop_dac", 32'(o_dac_data), 32'd0);
        push(0, 0, 0, 0);
        drain();

        // Reset asserted during S_FETCH
        setup(1'b0, 1'b0, 1'b0, 3'd0, 3, 16, 0, 0);
        push(0, 1, 0, 0); push(16, 1, 0, 1);
        pulse_start();
        wait_tick(); wait_tick(); wait_tick();
        @(negedge clk) i_rst = 1'b1;
        @(negedge clk) i_rst = 1'b0;
        chk("frst_addr", 32'(o_sram_addr), 32'd0);
        chk("frst_dac", 32'(o_dac_data), 32'd0);
        chk("frst_en", 32'(o_player_en), 32'd0);
        chk("frst_done", 32'(o_done), 32'd0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
